ram_16x8: RTL
=============

// Module: ram_16x8
// PURPOSE
//  Main memory behind memory_address_register: takes the registered address, serves
//  bus reads (output enable) and bus writes, and owns a program-mode loader that
//  fills memory before a run via a valid/ready handshake. Sits between the MAR, the
//  shared W-bus and the front-panel/testbench program source.
// PARAMETERS
//  ADDR_W   4              address width, matches MAR output
//  DATA_W   8              word width, matches W-bus
//  DEPTH    (1<<ADDR_W)    number of words; full address range always decoded
// PORTS
//  clk            in   1       rising-edge clock
//  clrbar         in   1       asynchronous reset, active low
//  address_in     in   ADDR_W  address from memory_address_register
//  data_in        in   DATA_W  write data from W-bus
//  ce_bar         in   1       active-low read enable (drive word to bus)
//  we_bar         in   1       active-low write enable (run mode)
//  prog_mode      in   1       1 = loader owns memory, run controls ignored
//  prog_valid     in   1       loader word offered
//  prog_ready     out  1       loader word accepted when valid&ready
//  prog_addr      in   ADDR_W  loader address
//  prog_data      in   DATA_W  loader data
//  data_out       out  DATA_W  registered read data
//  data_out_valid out  1       data_out holds a fresh read this cycle
//  bus_conflict   out  1       one-cycle pulse: ce_bar and we_bar both low
//  prog_count     out  ADDR_W+1 words written since entering PROG, saturates at DEPTH
// BEHAVIOUR
//  Reset (clrbar=0, async): all DEPTH words <= 0, data_out=0, data_out_valid=0,
//   bus_conflict=0, prog_ready=0, prog_count=0, state=RUN. Reset mid-handshake
//   abandons the word; nothing written.
//  States: RUN, PROG_IDLE, PROG_ACK.
//  RUN, sampled at posedge:
//   ce_bar=0,we_bar=1: data_out<=mem[address_in]; data_out_valid=1 next cycle (latency 1).
//   we_bar=0,ce_bar=1: mem[address_in]<=data_in; valid=0. Read-after-write to same
//    address on next cycle returns new data.
//   both 0: write performed, no read, valid=0, bus_conflict=1 for one cycle.
//   both 1: data_out holds last value, valid=0.
//   prog_mode=1: go PROG_IDLE next edge; run controls that cycle ignored; prog_count<=0.
//  PROG_IDLE: prog_ready=1. prog_valid=1 -> mem[prog_addr]<=prog_data,
//   prog_count<=min(prog_count+1,DEPTH), -> PROG_ACK. prog_mode=0 with no valid -> RUN.
//   prog_mode=0 and prog_valid=1 same cycle: word accepted, then RUN after PROG_ACK.
//  PROG_ACK: prog_ready=0 for exactly one cycle; -> PROG_IDLE if prog_mode else RUN.
//   Max loader throughput: one word per 2 cycles.
//  In PROG_*: data_out_valid=0, bus_conflict=0, data_out holds; ce_bar/we_bar ignored.
//  prog_ready is registered (function of state only), never combinational on valid.
//  prog_count holds its value on return to RUN until next PROG entry.
//  Addresses wrap naturally; no out-of-range case exists (DEPTH = 2**ADDR_W).
// STRUCTURE
//  Shared include sap_defs.vh: ADDR_W/DATA_W defaults, state encodings
//   (RUN=2'd0, PROG_IDLE=2'd1, PROG_ACK=2'd2).
//  Sub-module ram_prog_loader: state register, prog_ready, prog_count, write strobe
//   and mux select; ram_16x8 holds storage array, run-mode decode and read register.
// TESTING
//  Reset: pulse clrbar low mid-clock -> data_out=0, valid=0, all 16 reads return 8'h00.
//  Run write/read: we_bar=0 addr=4'h3 data=8'hA5; next cycle ce_bar=0 addr=3 ->
//   data_out=8'hA5 with valid=1 exactly one edge later.
//  Conflict: ce_bar=we_bar=0 addr=4'hF data=8'h5A -> bus_conflict 1 cycle, valid=0,
//   subsequent read of F returns 8'h5A.
//  Loader: prog_mode=1, offer 16 words addr i data 8'h10+i with valid held ->
//   ready toggles 1/0, prog_count ends at 5'd16, run reads match all 16.
//  Exit race: drop prog_mode in same cycle as last valid -> word written, PROG_ACK,
//   then RUN; ce_bar/we_bar pulses during PROG have no effect on memory.
//  Reset during PROG_ACK -> state RUN, prog_count=0, memory all 8'h00.

Source files
------------

// File: rtl/ram_16x8_pkg.sv
// ram_16x8_pkg: shared widths and loader state encoding for the 16x8 main memory.
package ram_16x8_pkg;
    localparam int DEF_ADDR_W = 4;
    localparam int DEF_DATA_W = 8;
    typedef enum logic [1:0] {
        RUN       = 2'd0,
        PROG_IDLE = 2'd1,
        PROG_ACK  = 2'd2
    } state_t;
endpackage

// File: rtl/ram_16x8_prog_loader.sv
// ram_16x8_prog_loader: program-mode handshake FSM with registered ready and saturating word count.
module ram_16x8_prog_loader
    import ram_16x8_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W
) (
    input  logic            clk,
    input  logic            clrbar,
    input  logic            prog_mode,
    input  logic            prog_valid,
    output logic            prog_ready,
    output logic [ADDR_W:0] prog_count,
    output logic            prog_we,
    output logic            prog_sel
);
    localparam logic [ADDR_W:0] ONE   = (ADDR_W+1)'(1);
    localparam logic [ADDR_W:0] DEPTH = ONE << ADDR_W;
    state_t state;
    assign prog_sel = state != RUN;
    assign prog_we  = state == PROG_IDLE && prog_valid;
    always_ff @(posedge clk or negedge clrbar) begin
        if (!clrbar) begin
            state      <= RUN;
            prog_ready <= 1'b0;
            prog_count <= '0;
        end else begin
            case (state)
                RUN: if (prog_mode) begin
                    state      <= PROG_IDLE;
                    prog_ready <= 1'b1;
                    prog_count <= '0;
                end
                PROG_IDLE: if (prog_valid) begin
                    state      <= PROG_ACK;
                    prog_ready <= 1'b0;
                    prog_count <= prog_count == DEPTH ? prog_count : prog_count + ONE;
                end else if (!prog_mode) begin
                    state      <= RUN;
                    prog_ready <= 1'b0;
                end
                // ready drops for exactly this one cycle, capping throughput at a word per two cycles
                PROG_ACK: begin
                    state      <= prog_mode ? PROG_IDLE : RUN;
                    prog_ready <= prog_mode;
                end
                default: begin
                    state      <= RUN;
                    prog_ready <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: rtl/ram_16x8.sv
// ram_16x8: main memory with run-mode bus read/write and a program-mode loader port.
module ram_16x8
    import ram_16x8_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W
) (
    input  logic              clk,
    input  logic              clrbar,
    input  logic [ADDR_W-1:0] address_in,
    input  logic [DATA_W-1:0] data_in,
    input  logic              ce_bar,
    input  logic              we_bar,
    input  logic              prog_mode,
    input  logic              prog_valid,
    output logic              prog_ready,
    input  logic [ADDR_W-1:0] prog_addr,
    input  logic [DATA_W-1:0] prog_data,
    output logic [DATA_W-1:0] data_out,
    output logic              data_out_valid,
    output logic              bus_conflict,
    output logic [ADDR_W:0]   prog_count
);
    localparam int DEPTH = 1 << ADDR_W;
    logic [DATA_W-1:0] mem [DEPTH];
    logic              prog_we, prog_sel, run, rd_en, wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;

    ram_16x8_prog_loader #(.ADDR_W(ADDR_W)) u_loader (
        .clk        (clk),
        .clrbar     (clrbar),
        .prog_mode  (prog_mode),
        .prog_valid (prog_valid),
        .prog_ready (prog_ready),
        .prog_count (prog_count),
        .prog_we    (prog_we),
        .prog_sel   (prog_sel)
    );

    // raising prog_mode in RUN already masks that cycle's bus controls
    assign run     = !prog_sel && !prog_mode;
    assign rd_en   = run && !ce_bar && we_bar;
    assign wr_en   = prog_sel ? prog_we : run && !we_bar;
    assign wr_addr = prog_sel ? prog_addr : address_in;
    assign wr_data = prog_sel ? prog_data : data_in;

    always_ff @(posedge clk or negedge clrbar) begin
        if (!clrbar) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
            data_out       <= '0;
            data_out_valid <= 1'b0;
            bus_conflict   <= 1'b0;
        end else begin
            if (wr_en) mem[wr_addr] <= wr_data;
            if (rd_en) data_out <= mem[address_in];
            data_out_valid <= rd_en;
            bus_conflict   <= run && !ce_bar && !we_bar;
        end
    end
endmodule
